// File: rtl/cnn_pkg.sv
// Shared CNN front-end types and constants: pixel format, kernel size,
// default image geometry and the window generator FSM states.
package cnn_pkg;

    localparam int PIXEL_W       = 16;
    localparam int KERNEL        = 3;
    localparam int IMG_W_DEFAULT = 28;
    localparam int IMG_H_DEFAULT = 28;
    localparam int WINDOW_W      = PIXEL_W * KERNEL * KERNEL;

    typedef logic [PIXEL_W-1:0] pixel_t;

    // One window column, oldest row first.
    typedef struct packed {
        pixel_t r2;
        pixel_t r1;
        pixel_t r0;
    } column_t;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } win_state_e;

    // Row-major, oldest first: element 0 ends up in the LSBs.
    function automatic logic [WINDOW_W-1:0] pack_window(
        input column_t c_m2,
        input column_t c_m1,
        input column_t c_0
    );
        return {c_0.r0, c_m1.r0, c_m2.r0,
                c_0.r1, c_m1.r1, c_m2.r1,
                c_0.r2, c_m1.r2, c_m2.r2};
    endfunction

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel stream in / window stream out bundle for window_3x3_gen.
interface window_3x3_gen_if;
    import cnn_pkg::*;

    logic                valid_in;
    logic [PIXEL_W-1:0]  pixel_in;
    logic                valid_out;
    logic [WINDOW_W-1:0] window_out;
    logic                frame_done;

    modport master (
        output valid_in, pixel_in,
        input  valid_out, window_out, frame_done
    );

    modport slave (
        input  valid_in, pixel_in,
        output valid_out, window_out, frame_done
    );

endinterface

// File: rtl/line_buffer.sv
// One image row of storage: single index, read-before-write, registered read.
module line_buffer #(
    parameter  int DEPTH = 28,
    parameter  int WIDTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the storage array has no reset so it maps onto block RAM; stale
    // contents are harmless because the window logic refills before use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    // Read data holds between enables so downstream windows stay stable.
    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = mem_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/window_3x3_gen.sv
// Raster-order pixel stream to 3x3 sliding windows (valid convolution, no
// padding); one window per accepted pixel once two full rows are buffered.
module window_3x3_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEFAULT,
    parameter int IMG_H = IMG_H_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [PIXEL_W-1:0]  pixel_in,
    output logic                valid_out,
    output logic [WINDOW_W-1:0] window_out,
    output logic                frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST        = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_FIRST_VALID = COL_W'(KERNEL - 1);
    localparam logic [ROW_W-1:0] ROW_LAST        = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_FILL_LAST   = ROW_W'(KERNEL - 2);

    logic [COL_W-1:0] col_d, col_q;
    logic [ROW_W-1:0] row_d, row_q;
    logic             wr_sel_d, wr_sel_q;
    logic             rd_sel_d, rd_sel_q;
    pixel_t           pix_d, pix_q;
    column_t          col_m1_d, col_m1_q;
    column_t          col_m2_d, col_m2_q;
    column_t          col_new;

    win_state_e       state_q;
    logic             valid_out_q;
    logic             frame_done_q;

    logic             accept;
    logic             row_end;
    logic             fill_end;
    logic             frame_end;
    pixel_t           rd_a;
    pixel_t           rd_b;

    assign accept    = valid_in & rst;
    assign row_end   = accept && (col_q == COL_LAST);
    assign fill_end  = row_end && (row_q == ROW_FILL_LAST);
    assign frame_end = row_end && (row_q == ROW_LAST);

    // The two buffers swap roles every row: the one written with row r still
    // holds row r-2, so its read-before-write data is the r-2 sample and the
    // other buffer supplies r-1. This is the r-1 -> r-2 shift with one write
    // port per buffer and no extra read latency.
    line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIXEL_W)
    ) u_lb_a (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .we    (accept & ~wr_sel_q),
        .idx   (col_q),
        .wdata (pixel_in),
        .rdata (rd_a)
    );

    line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIXEL_W)
    ) u_lb_b (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .we    (accept & wr_sel_q),
        .idx   (col_q),
        .wdata (pixel_in),
        .rdata (rd_b)
    );

    // Newest column: buffer reads land one cycle after acceptance, alongside pix_q.
    always_comb begin
        col_new.r2 = rd_sel_q ? rd_b : rd_a;
        col_new.r1 = rd_sel_q ? rd_a : rd_b;
        col_new.r0 = pix_q;
    end

    // NOTE: every always_comb output is first assigned its hold value so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        pix_d    = pix_q;
        col_m1_d = col_m1_q;
        col_m2_d = col_m2_q;
        if (accept) begin
            rd_sel_d = wr_sel_q;
            pix_d    = pixel_in;
            col_m1_d = col_new;
            col_m2_d = col_m1_q;
            if (row_end) begin
                col_d    = '0;
                wr_sel_d = ~wr_sel_q;
                row_d    = frame_end ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d    = col_q + COL_W'(1);
            end
        end
    end

    // NOTE: reset is synchronous and active-low; it is sampled only on the
    // clock edge, so it appears in the body of the always_ff, not its list.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q    <= '0;
            row_q    <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            pix_q    <= '0;
            col_m1_q <= '0;
            col_m2_q <= '0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            pix_q    <= pix_d;
            col_m1_q <= col_m1_d;
            col_m2_q <= col_m2_d;
        end
    end

    // FILL covers rows 0 and 1, where the buffers do not yet hold two rows.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= FILL;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            valid_out_q  <= accept && (state_q == STREAM) && (col_q >= COL_FIRST_VALID);
            frame_done_q <= frame_end;
            case (state_q)
                FILL:    if (fill_end)  state_q <= STREAM;
                STREAM:  if (frame_end) state_q <= FILL;
                default: state_q <= FILL;
            endcase
        end
    end

    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;
    assign window_out = pack_window(col_m2_q, col_m1_q, col_new);

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen: 4x4 frames (continuous, gapped,
// back-to-back, reset mid-frame) and one all-ones 28x28 frame.
module tb_window_3x3_gen;
    import cnn_pkg::*;

    logic clk;
    logic rst;

    window_3x3_gen_if ifs ();
    window_3x3_gen_if ifl ();

    window_3x3_gen #(.IMG_W(4), .IMG_H(4)) dut_s (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (ifs.valid_in),
        .pixel_in   (ifs.pixel_in),
        .valid_out  (ifs.valid_out),
        .window_out (ifs.window_out),
        .frame_done (ifs.frame_done)
    );

    window_3x3_gen #(.IMG_W(28), .IMG_H(28)) dut_l (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (ifl.valid_in),
        .pixel_in   (ifl.pixel_in),
        .valid_out  (ifl.valid_out),
        .window_out (ifl.window_out),
        .frame_done (ifl.frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Small-DUT monitor state.
    logic                s_acc = 1'b0;
    logic [WINDOW_W-1:0] s_wins [$];
    logic [WINDOW_W-1:0] s_fd_win = '0;
    int                  s_vo = 0, s_fd = 0, s_fd_alone = 0, s_stray = 0;

    // Large-DUT monitor state.
    int                  l_vo = 0, l_fd = 0, l_bad = 0;

    always @(posedge clk) s_acc = ifs.valid_in & rst;

    always @(negedge clk) begin
        if (ifs.valid_out === 1'b1) begin
            s_wins.push_back(ifs.window_out);
            s_vo++;
            if (!s_acc) s_stray++;
        end
        if (ifs.frame_done === 1'b1) begin
            s_fd++;
            s_fd_win = ifs.window_out;
            if (ifs.valid_out !== 1'b1) s_fd_alone++;
        end
        if (ifl.valid_out === 1'b1) begin
            l_vo++;
            for (int k = 0; k < 9; k++) begin
                if (ifl.window_out[16*k +: 16] !== 16'hFFFF) l_bad++;
            end
        end
        if (ifl.frame_done === 1'b1) l_fd++;
    end

    task automatic check(input string tag, input logic [WINDOW_W-1:0] got,
                         input logic [WINDOW_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [WINDOW_W-1:0] pack9(input int e [9]);
        logic [WINDOW_W-1:0] w;
        for (int k = 0; k < 9; k++) w[16*k +: 16] = 16'(e[k]);
        return w;
    endfunction

    // Window ending at (r,c) of a 4x4 frame with pixel = base + r*4 + c.
    function automatic logic [WINDOW_W-1:0] exp_win(input int base, input int r, input int c);
        logic [WINDOW_W-1:0] w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[16*(i*3+j) +: 16] = 16'(base + (r - 2 + i) * 4 + (c - 2 + j));
        return w;
    endfunction

    function automatic logic [WINDOW_W-1:0] s_win_at(input int i);
        if (i < s_wins.size()) return s_wins[i];
        return 'x;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic s_send(input int value, input int gap);
        ifs.valid_in = 1'b1;
        ifs.pixel_in = 16'(value);
        idle(1);
        ifs.valid_in = 1'b0;
        idle(gap);
    endtask

    task automatic s_frame(input int base, input bit gaps, input int n_pix);
        for (int p = 0; p < n_pix; p++)
            s_send(base + p, gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic frame_checks(input string tag, input int idx0, input int vo0,
                                input int fd0, input int alone0, input int stray0);
        int a [9];
        check({tag, " count"}, WINDOW_W'(s_vo - vo0), WINDOW_W'(4));
        a = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        check({tag, " first"}, s_win_at(idx0), pack9(a));
        a = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        check({tag, " last"}, s_win_at(idx0 + 3), pack9(a));
        for (int n = 0; n < 4; n++)
            check({tag, " win"}, s_win_at(idx0 + n), exp_win(0, 2 + n / 2, 2 + n % 2));
        check({tag, " fd count"}, WINDOW_W'(s_fd - fd0), WINDOW_W'(1));
        check({tag, " fd alone"}, WINDOW_W'(s_fd_alone - alone0), WINDOW_W'(0));
        check({tag, " fd window"}, s_fd_win, pack9(a));
        check({tag, " stray"}, WINDOW_W'(s_stray - stray0), WINDOW_W'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " s valid"}, WINDOW_W'(ifs.valid_out), WINDOW_W'(0));
        check({tag, " s done"},  WINDOW_W'(ifs.frame_done), WINDOW_W'(0));
        check({tag, " s window"}, ifs.window_out, WINDOW_W'(0));
    endtask

    initial begin
        int idx0, vo0, fd0, alone0, stray0;
        int a [9];

        rst = 1'b0;
        ifs.valid_in = 1'b0;
        ifs.pixel_in = '0;
        ifl.valid_in = 1'b0;
        ifl.pixel_in = '0;

        // Reset state.
        idle(3);
        check_reset_outputs("rst");
        check("rst l valid",  WINDOW_W'(ifl.valid_out), WINDOW_W'(0));
        check("rst l done",   WINDOW_W'(ifl.frame_done), WINDOW_W'(0));
        check("rst l window", ifl.window_out, WINDOW_W'(0));
        rst = 1'b1;
        idle(1);

        // Continuous frame.
        idx0 = s_wins.size(); vo0 = s_vo; fd0 = s_fd; alone0 = s_fd_alone; stray0 = s_stray;
        s_frame(0, 1'b0, 16);
        idle(2);
        frame_checks("cont", idx0, vo0, fd0, alone0, stray0);

        // Same frame with random idle gaps.
        idx0 = s_wins.size(); vo0 = s_vo; fd0 = s_fd; alone0 = s_fd_alone; stray0 = s_stray;
        s_frame(0, 1'b1, 16);
        idle(2);
        frame_checks("gaps", idx0, vo0, fd0, alone0, stray0);

        // Two back-to-back frames.
        idx0 = s_wins.size(); vo0 = s_vo; fd0 = s_fd; alone0 = s_fd_alone; stray0 = s_stray;
        s_frame(0, 1'b0, 16);
        s_frame(100, 1'b0, 16);
        idle(2);
        check("b2b count", WINDOW_W'(s_vo - vo0), WINDOW_W'(8));
        check("b2b fd count", WINDOW_W'(s_fd - fd0), WINDOW_W'(2));
        a = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
        check("b2b f2 first", s_win_at(idx0 + 4), pack9(a));
        for (int n = 0; n < 8; n++)
            check("b2b win", s_win_at(idx0 + n), exp_win((n < 4) ? 0 : 100, 2 + (n % 4) / 2, 2 + n % 2));
        check("b2b stray", WINDOW_W'(s_stray - stray0), WINDOW_W'(0));

        // Reset after pixel (2,3), with valid_in held high during reset.
        s_frame(0, 1'b0, 12);
        ifs.valid_in = 1'b1;
        ifs.pixel_in = 16'h1234;
        rst = 1'b0;
        idle(1);
        check_reset_outputs("midrst 1");
        idle(1);
        check_reset_outputs("midrst 2");
        rst = 1'b1;
        ifs.valid_in = 1'b0;
        idle(1);
        idx0 = s_wins.size(); vo0 = s_vo; fd0 = s_fd; alone0 = s_fd_alone; stray0 = s_stray;
        s_frame(0, 1'b0, 16);
        idle(2);
        frame_checks("postrst", idx0, vo0, fd0, alone0, stray0);

        // Full-size all-ones frame on the 28x28 instance.
        ifl.pixel_in = 16'hFFFF;
        ifl.valid_in = 1'b1;
        idle(28 * 28);
        ifl.valid_in = 1'b0;
        idle(3);
        check("big count", WINDOW_W'(l_vo), WINDOW_W'(676));
        check("big elems", WINDOW_W'(l_bad), WINDOW_W'(0));
        check("big fd count", WINDOW_W'(l_fd), WINDOW_W'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
